// File: rtl/plru_tree_sets_if.sv
// ---------------------------------------------------------------------------
// plru_tree_sets_if
//   Request/response bundle for the tree pseudo-LRU replacement engine.
//   The cache controller drives through the master modport. The PLRU engine
//   uses the slave modport.
//
//   acc_valid  : touch request (hit, or fill after a miss)
//   acc_set    : set being touched
//   acc_way    : way being touched
//   vic_req    : victim request
//   vic_set    : set the victim is wanted for
//   valid_mask : per-way line-valid bits of vic_set (bit i = way i)
//   lock_mask  : per-way lock bits of vic_set (1 = never choose this way)
//   vic_valid  : one-cycle pulse, the victim response is present
//   vic_way    : selected victim way (held until the next response)
//   vic_none   : qualifies vic_valid; every way was locked
// ---------------------------------------------------------------------------
interface plru_tree_sets_if #(
    parameter int WAYS = 8,
    parameter int SETS = 64
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic             acc_valid;
    logic [SET_W-1:0] acc_set;
    logic [WAY_W-1:0] acc_way;
    logic             vic_req;
    logic [SET_W-1:0] vic_set;
    logic [WAYS-1:0]  valid_mask;
    logic [WAYS-1:0]  lock_mask;
    logic             vic_valid;
    logic [WAY_W-1:0] vic_way;
    logic             vic_none;

    modport master (
        output acc_valid, acc_set, acc_way,
        output vic_req, vic_set, valid_mask, lock_mask,
        input  vic_valid, vic_way, vic_none
    );

    modport slave (
        input  acc_valid, acc_set, acc_way,
        input  vic_req, vic_set, valid_mask, lock_mask,
        output vic_valid, vic_way, vic_none
    );
endinterface

// File: rtl/plru_tree_sets.sv
// ---------------------------------------------------------------------------
// plru_tree_sets
//   Tree pseudo-LRU replacement engine. It holds one (WAYS-1)-bit tree per
//   set.
//   The tree is heap-ordered. Node 0 is the root, and the children of node n
//   are 2n+1 (lower half of the ways) and 2n+2 (upper half of the ways).
//   A node bit of 0 sends the victim walk to the lower half. A node bit of 1
//   sends it to the upper half.
//
//   The engine accepts one touch and one victim request per cycle. The
//   victim is chosen from the tree state before any touch in the same cycle.
//   The choice is registered, so the answer appears one cycle after vic_req.
//   The victim is chosen in this order:
//     1. the lowest-index way that is both invalid and unlocked;
//     2. the tree walk, steering around subtrees that are entirely locked;
//     3. vic_none=1 with vic_way=0 when every way is locked.
//   A victim lookup never changes the tree. The caller touches the way when
//   the fill happens.
//
// Ports
//   clk : clock
//   rst : synchronous, active-high reset. It clears all trees and the
//         response registers, and discards that cycle's requests.
//   bus : plru_tree_sets_if.slave (see the interface header)
// ---------------------------------------------------------------------------
module plru_tree_sets #(
    parameter int WAYS = 8,
    parameter int SETS = 64
) (
    input  logic               clk,
    input  logic               rst,
    plru_tree_sets_if.slave    bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int NODES = WAYS - 1;
    // Make the array cover the whole index range. This only differs from
    // SETS when SETS == 1, where the set index is still one bit wide.
    localparam int DEPTH = 1 << SET_W;

    logic [NODES-1:0] tree_reg [DEPTH];

    logic [NODES-1:0] vic_tree;    // tree of vic_set, before any update
    logic [NODES-1:0] acc_tree;    // tree of acc_set, before any update
    logic [NODES-1:0] tree_next;   // acc_set tree after the touch
    logic [NODES-1:0] touch_mask;  // nodes on the root->acc_way path
    logic [NODES-1:0] touch_val;   // value those nodes take
    logic [NODES-1:0] dir_node;    // lock-aware walk direction per node (1 = upper)

    logic             vic_valid_reg;
    logic [WAY_W-1:0] vic_way_reg, vic_way_next;
    logic             vic_none_reg, vic_none_next;

    logic [WAYS-1:0]  free_ways;
    logic             free_hit;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] walk_way;

    assign vic_tree = tree_reg[bus.vic_set];
    assign acc_tree = tree_reg[bus.acc_set];

    // Per-node logic. Level gi has 2^gi nodes. Node gk of that level covers
    // the ways [gk*SPAN, (gk+1)*SPAN).
    for (genvar gi = 0; gi < WAY_W; gi++) begin : gen_level
        for (genvar gk = 0; gk < (1 << gi); gk++) begin : gen_node
            localparam int NODE = (1 << gi) - 1 + gk;
            localparam int SPAN = WAYS >> gi;
            localparam int HALF = SPAN / 2;
            localparam int LO   = gk * SPAN;

            logic lo_locked;
            logic hi_locked;
            logic on_path;

            assign lo_locked = &bus.lock_mask[LO +: HALF];
            assign hi_locked = &bus.lock_mask[LO + HALF +: HALF];

            // Follow the node bit, unless that child's subtree is fully
            // locked. Then take the sibling.
            assign dir_node[NODE] = vic_tree[NODE] ? ~hi_locked : lo_locked;

            if (gi == 0) begin : gen_root
                assign on_path = 1'b1;
            end else begin : gen_inner
                localparam logic [gi-1:0] IDX = gk;
                assign on_path = (bus.acc_way[WAY_W-1 -: gi] == IDX);
            end

            // Point away from the touched way. A touch in the lower half
            // sets the bit to 1; a touch in the upper half sets it to 0.
            assign touch_mask[NODE] = on_path;
            assign touch_val[NODE]  = ~bus.acc_way[WAY_W-1-gi];
        end
    end

    // Tree walk. Each level appends one way bit. That bit is taken from the
    // level's direction vector, indexed by the prefix chosen so far.
    for (genvar gi = 0; gi < WAY_W; gi++) begin : gen_walk
        logic [gi:0] path;
        if (gi == 0) begin : gen_first
            assign path = dir_node[0];
        end else begin : gen_next
            logic [(1<<gi)-1:0] lvl_dir;
            assign lvl_dir = dir_node[(1 << gi) - 1 +: (1 << gi)];
            assign path    = {gen_walk[gi-1].path, lvl_dir[gen_walk[gi-1].path]};
        end
    end
    assign walk_way = gen_walk[WAY_W-1].path;

    // Priority 1: the lowest-index way that is invalid and unlocked.
    always_comb begin
        free_ways = ~bus.valid_mask & ~bus.lock_mask;
        free_hit  = |free_ways;
        free_way  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (free_ways[i]) begin
                free_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        vic_none_next = &bus.lock_mask;
        vic_way_next  = walk_way;
        if (vic_none_next) begin
            vic_way_next = '0;
        end else if (free_hit) begin
            vic_way_next = free_way;
        end
    end

    assign tree_next = (acc_tree & ~touch_mask) | (touch_val & touch_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tree_reg[i] <= '0;
            end
            vic_valid_reg <= 1'b0;
            vic_way_reg   <= '0;
            vic_none_reg  <= 1'b0;
        end else begin
            if (bus.acc_valid) begin
                tree_reg[bus.acc_set] <= tree_next;
            end
            vic_valid_reg <= bus.vic_req;
            if (bus.vic_req) begin
                vic_way_reg  <= vic_way_next;
                vic_none_reg <= vic_none_next;
            end
        end
    end

    assign bus.vic_valid = vic_valid_reg;
    assign bus.vic_way   = vic_way_reg;
    assign bus.vic_none  = vic_none_reg;
endmodule

// File: tb/tb_plru_tree_sets.sv
// ---------------------------------------------------------------------------
// tb_plru_tree_sets
//   Exercises a 4-way/8-set engine and an 8-way/64-set engine.
//   The 4-way engine runs directed scenarios. The 8-way engine runs
//   directed scenarios and a long random touch/victim sequence. The random
//   results are compared against a behavioural model that works on way
//   ranges with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_plru_tree_sets;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plru_tree_sets_if #(.WAYS(4), .SETS(8))  bus4();
    plru_tree_sets_if #(.WAYS(8), .SETS(64)) bus8();

    plru_tree_sets #(.WAYS(4), .SETS(8))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    plru_tree_sets #(.WAYS(8), .SETS(64)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int checks   = 0;
    int failures = 0;

    // Model state: one integer per set. Bit n is tree node n.
    int mt4 [8];
    int mt8 [64];
    // Expected response registers.
    bit e8_valid;
    int e8_way;
    bit e8_none;

    // Victim per the selection rules. Returns -1 when every way is locked.
    function automatic int ref_victim(int ways, int t, int vm, int lm);
        int node, lo, span, half, hm;
        bit lower_locked, upper_locked, go_up;
        for (int i = 0; i < ways; i++)
            if (((vm >> i) & 1) == 0 && ((lm >> i) & 1) == 0) return i;
        if ((lm & ((1 << ways) - 1)) == (1 << ways) - 1) return -1;
        node = 0; lo = 0; span = ways;
        while (span > 1) begin
            half = span / 2;
            hm = (1 << half) - 1;
            lower_locked = ((lm >> lo) & hm) == hm;
            upper_locked = ((lm >> (lo + half)) & hm) == hm;
            go_up = ((t >> node) & 1) ? !upper_locked : lower_locked;
            if (go_up) lo += half;
            node = 2 * node + 1 + int'(go_up);
            span = half;
        end
        return lo;
    endfunction

    // Touch: each node on the way's path is made to point at the other half.
    function automatic int ref_touch(int ways, int t, int way);
        int node, lo, span, half, r;
        r = t; node = 0; lo = 0; span = ways;
        while (span > 1) begin
            half = span / 2;
            if (way < lo + half) begin
                r = r | (1 << node);
                node = 2 * node + 1;
            end else begin
                r = r & ~(1 << node);
                lo += half;
                node = 2 * node + 2;
            end
            span = half;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus4.acc_valid = 1'b0; bus4.vic_req = 1'b0;
        bus8.acc_valid = 1'b0; bus8.vic_req = 1'b0;
    endtask

    // One cycle on the 4-way engine. Outputs can be read on return.
    task automatic cyc4(input bit av, input int as, input int aw,
                        input bit vr, input int vs, input int vm, input int lm);
        bus4.acc_valid = av; bus4.acc_set = 3'(as); bus4.acc_way = 2'(aw);
        bus4.vic_req = vr; bus4.vic_set = 3'(vs);
        bus4.valid_mask = 4'(vm); bus4.lock_mask = 4'(lm);
        if (av) mt4[as] = ref_touch(4, mt4[as], aw);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // One cycle on the 8-way engine. The model's expected response is
    // updated first, then the model tree.
    task automatic cyc8(input bit av, input int as, input int aw,
                        input bit vr, input int vs, input int vm, input int lm);
        int v;
        bus8.acc_valid = av; bus8.acc_set = 6'(as); bus8.acc_way = 3'(aw);
        bus8.vic_req = vr; bus8.vic_set = 6'(vs);
        bus8.valid_mask = 8'(vm); bus8.lock_mask = 8'(lm);
        e8_valid = vr;
        if (vr) begin
            v = ref_victim(8, mt8[vs], vm, lm);
            e8_none = (v < 0);
            e8_way  = (v < 0) ? 0 : v;
        end
        if (av) mt8[as] = ref_touch(8, mt8[as], aw);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Requests that arrive in the reset cycle must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        bus4.acc_valid = 1'b1; bus4.acc_set = 3'd3; bus4.acc_way = 2'd0;
        bus4.vic_req = 1'b1; bus4.vic_set = 3'd3;
        bus4.valid_mask = '1; bus4.lock_mask = '0;
        bus8.acc_valid = 1'b1; bus8.acc_set = 6'd1; bus8.acc_way = 3'd0;
        bus8.vic_req = 1'b1; bus8.vic_set = 6'd1;
        bus8.valid_mask = '1; bus8.lock_mask = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        foreach (mt4[i]) mt4[i] = 0;
        foreach (mt8[i]) mt8[i] = 0;
        e8_valid = 0; e8_way = 0; e8_none = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus4.vic_valid !== 1'b0 || bus4.vic_way !== 2'd0 || bus4.vic_none !== 1'b0) begin
            failures++;
            $display("FAIL reset4: valid/way/none=%b/%0d/%b want 0/0/0", bus4.vic_valid, bus4.vic_way, bus4.vic_none);
        end
        checks++;
        if (bus8.vic_valid !== 1'b0 || bus8.vic_way !== 3'd0 || bus8.vic_none !== 1'b0) begin
            failures++;
            $display("FAIL reset8: valid/way/none=%b/%0d/%b want 0/0/0", bus8.vic_valid, bus8.vic_way, bus8.vic_none);
        end
        cyc4(0, 0, 0, 1, 5, 'hF, 0);
        checks++;
        if (bus4.vic_valid !== 1'b1 || bus4.vic_way !== 2'd0 || bus4.vic_none !== 1'b0) begin
            failures++;
            $display("FAIL first_victim: valid/way/none=%b/%0d/%b want 1/0/0", bus4.vic_valid, bus4.vic_way, bus4.vic_none);
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_touch_order();
        do_reset();
        for (int w = 0; w < 4; w++) cyc4(1, 5, w, 0, 0, 'hF, 0);
        cyc4(0, 0, 0, 1, 5, 'hF, 0);
        checks++;
        if (bus4.vic_valid !== 1'b1 || bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL touch_all: valid/way=%b/%0d want 1/0", bus4.vic_valid, bus4.vic_way);
        end
        // The response pulses for one cycle, and the way is held.
        cyc4(1, 5, 0, 0, 0, 'hF, 0);
        checks++;
        if (bus4.vic_valid !== 1'b0 || bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL pulse_hold: valid/way=%b/%0d want 0/0", bus4.vic_valid, bus4.vic_way);
        end
        cyc4(0, 0, 0, 1, 5, 'hF, 0);
        checks++;
        if (bus4.vic_way !== 2'd2) begin
            failures++;
            $display("FAIL after_touch0: way=%0d want 2", bus4.vic_way);
        end
        cyc4(0, 0, 0, 1, 6, 'hF, 0);
        checks++;
        if (bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL set_isolation: way=%0d want 0", bus4.vic_way);
        end
        $display("test_touch_order done checks=%0d", checks);
    endtask

    task automatic test_locks();
        int lm_tab [3] = '{'b0001, 'b0011, 'b1111};
        int way_tab[3] = '{1, 2, 0};
        int non_tab[3] = '{0, 0, 1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc4(0, 0, 0, 1, 2, 'hF, lm_tab[i]);
            checks++;
            if (bus4.vic_valid !== 1'b1 || int'(bus4.vic_way) != way_tab[i] || int'(bus4.vic_none) != non_tab[i]) begin
                failures++;
                $display("FAIL lock_%0d: valid/way/none=%b/%0d/%b want 1/%0d/%0d",
                         i, bus4.vic_valid, bus4.vic_way, bus4.vic_none, way_tab[i], non_tab[i]);
            end
        end
        $display("test_locks done checks=%0d", checks);
    endtask

    task automatic test_invalid();
        do_reset();
        cyc4(0, 0, 0, 1, 1, 'b1011, 'b0000);
        checks++;
        if (bus4.vic_way !== 2'd2 || bus4.vic_none !== 1'b0) begin
            failures++;
            $display("FAIL invalid_first: way/none=%0d/%b want 2/0", bus4.vic_way, bus4.vic_none);
        end
        cyc4(0, 0, 0, 1, 1, 'b1011, 'b0100);
        checks++;
        if (bus4.vic_way !== 2'd0 || bus4.vic_none !== 1'b0) begin
            failures++;
            $display("FAIL invalid_locked: way/none=%0d/%b want 0/0", bus4.vic_way, bus4.vic_none);
        end
        $display("test_invalid done checks=%0d", checks);
    endtask

    task automatic test_same_cycle();
        do_reset();
        cyc4(1, 3, 0, 1, 3, 'hF, 0);
        checks++;
        if (bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL same_cycle_pre: way=%0d want 0", bus4.vic_way);
        end
        cyc4(0, 0, 0, 1, 3, 'hF, 0);
        checks++;
        if (bus4.vic_way !== 2'd2) begin
            failures++;
            $display("FAIL same_cycle_post: way=%0d want 2", bus4.vic_way);
        end
        // Reset arrives while a victim request is pending.
        rst = 1'b1;
        cyc4(0, 0, 0, 1, 3, 'hF, 0);
        rst = 1'b0;
        checks++;
        if (bus4.vic_valid !== 1'b0 || bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_in_req: valid/way=%b/%0d want 0/0", bus4.vic_valid, bus4.vic_way);
        end
        cyc4(0, 0, 0, 1, 3, 'hF, 0);
        checks++;
        if (bus4.vic_valid !== 1'b1 || bus4.vic_way !== 2'd0) begin
            failures++;
            $display("FAIL tree_cleared: valid/way=%b/%0d want 1/0", bus4.vic_valid, bus4.vic_way);
        end
        $display("test_same_cycle done checks=%0d", checks);
    endtask

    task automatic test_ways8();
        do_reset();
        for (int w = 0; w < 8; w++) cyc8(1, 63, w, 0, 0, 'hFF, 0);
        cyc8(0, 0, 0, 1, 63, 'hFF, 0);
        checks++;
        if (bus8.vic_way !== 3'd0) begin
            failures++;
            $display("FAIL w8_order: way=%0d want 0", bus8.vic_way);
        end
        cyc8(1, 63, 0, 0, 0, 'hFF, 0);
        cyc8(0, 0, 0, 1, 63, 'hFF, 0);
        checks++;
        if (bus8.vic_way !== 3'd4) begin
            failures++;
            $display("FAIL w8_touch0: way=%0d want 4", bus8.vic_way);
        end
        $display("test_ways8 done checks=%0d", checks);
    endtask

    task automatic test_random();
        int as, vs, vm, lm, r;
        bit av, vr;
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            av = ($urandom_range(0, 3) != 0);
            vr = ($urandom_range(0, 3) != 0);
            as = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            vs = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0) vs = as;
            vm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 'hFF;
            r  = $urandom_range(0, 19);
            lm = (r < 4) ? int'($urandom_range(0, 255)) : (r == 4) ? 'hFF : 0;
            cyc8(av, as, $urandom_range(0, 7), vr, vs, vm, lm);
            checks++;
            if (bus8.vic_valid !== e8_valid || int'(bus8.vic_way) != e8_way || bus8.vic_none !== e8_none) begin
                failures++;
                $display("FAIL rand_%0d: valid/way/none=%b/%0d/%b want %0d/%0d/%0d",
                         n, bus8.vic_valid, bus8.vic_way, bus8.vic_none, e8_valid, e8_way, e8_none);
            end
        end
        $display("test_random done checks=%0d", checks);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus4.acc_set = '0; bus4.acc_way = '0; bus4.vic_set = '0;
        bus4.valid_mask = '1; bus4.lock_mask = '0;
        bus8.acc_set = '0; bus8.acc_way = '0; bus8.vic_set = '0;
        bus8.valid_mask = '1; bus8.lock_mask = '0;
        test_reset();
        test_touch_order();
        test_locks();
        test_invalid();
        test_same_cycle();
        test_ways8();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plru_tree_sets.md
Name: plru_tree_sets

Overview:
- Parametrised tree pseudo-LRU replacement engine for set-associative shared-memory/LDS-backed caches. Successor to the 4-way single-set PLRU.
- Holds one (WAYS-1)-bit tree per set.
- Accepts one touch (hit or fill) per cycle and one victim request per cycle, with a 1-cycle registered victim response.
- Adds invalid-way priority, per-request way locking, and an all-locked indication.

Parameters:
WAYS, 8, associativity; power of 2, 2..32
SETS, 64, number of sets; power of 2, >=1
WAY_W, $clog2(WAYS), way index width (derived, localparam)
SET_W, max(1,$clog2(SETS)), set index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
acc_valid  in  1  touch request (hit, or fill after miss)
acc_set  in  SET_W  set being touched
acc_way  in  WAY_W  way being touched
vic_req  in  1  victim request
vic_set  in  SET_W  set for victim request
valid_mask  in  WAYS  per-way line-valid bits for vic_set; bit i = way i
lock_mask  in  WAYS  per-way lock bits for vic_set; 1 = way must not be chosen
vic_valid  out  1  victim response valid (1-cycle pulse)
vic_way  out  WAY_W  selected victim way
vic_none  out  1  qualifies vic_valid: no selectable way (all locked)

Behaviour:
- State: SETS x (WAYS-1) flop array, heap-indexed per set.
  - Node 0 is the root; children of node n are 2n+1 (lower-way half) and 2n+2 (upper-way half).
  - Node bit 0 means the victim path goes to the lower half; 1 means the upper half.
- Reset (rst=1 at posedge): all tree bits = 0; vic_valid=0, vic_way=0, vic_none=0. The reset cycle's acc_valid/vic_req are discarded.
- Touch: on acc_valid, every node on the path root->leaf(acc_way) in acc_set is written to point away from acc_way.
  - acc_way in the lower half of a node: node bit := 1.
  - acc_way in the upper half: node bit := 0.
  - Nodes off the path and other sets are unchanged. Takes effect at the next posedge.
- Victim selection is computed combinationally from the pre-update state of vic_set and registered. vic_valid is high the cycle after vic_req; vic_way and vic_none hold until the next response or reset.
  - Priority 1: the lowest-index way with valid_mask=0 and lock_mask=0.
  - Priority 2: tree walk from the root. At each node, take the bit-indicated child, unless every way under that child is locked; then take the sibling.
  - Priority 3: if all WAYS are locked, vic_none=1 and vic_way=0.
- Victim selection never modifies tree state. The caller must issue a touch when the fill occurs.
- Simultaneous acc_valid and vic_req, same set: the victim uses the state before the touch; the touch is still applied. Different sets: the two are independent.
- Back-to-back vic_req is allowed every cycle; throughput is 1 response/cycle.
- valid_mask and lock_mask are sampled only in the vic_req cycle.
- WAYS=2: single node; the tree walk reduces to one bit.

Test Plan:
- WAYS=4, SETS=8, reset; vic_req set5, masks all-valid/unlocked -> next cycle vic_valid=1, vic_way=0, vic_none=0.
- WAYS=4: touch set5 ways 0,1,2,3 then vic_req set5 -> way0; touch way0, vic_req -> way2; vic_req set6 -> way0 (set isolation).
- WAYS=4, after reset, all valid:
  - lock_mask=0001 -> way1.
  - lock_mask=0011 -> way2.
  - lock_mask=1111 -> vic_none=1, vic_way=0.
- WAYS=4, after reset:
  - valid_mask=1011, lock=0000 -> way2 (invalid priority).
  - valid_mask=1011, lock=0100 -> way0 (locked invalid way ignored).
- After reset, same cycle: vic_req set3 and acc set3 way0 -> vic_way=0; next vic_req set3 -> way2. Then assert rst in a vic_req cycle -> vic_valid=0 next cycle, set3 victim returns to 0.
- WAYS=8, SETS=64: touch ways 0..7 in order in set63 -> victim 0; touch way0 -> victim 4; random touch/victim sequences checked against a reference tree model for 10k cycles.
